// File: rtl/lsu_mem_arbiter.sv
// Two-lane LSU memory arbiter: one outstanding access, round-robin on simultaneous requests.
// Build option LSU_ARB_FIXED_PRIO_EN: lane 0 always wins ties and the pointer is removed.
module lsu_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t            state_r, state_s;
  logic              owner_r, owner_s;
  logic              pend_r, pend_s;
  logic              win_s;
  logic              load_s, load_lane_s;
  logic              done0_s, done1_s, stall_s;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

`ifdef LSU_ARB_FIXED_PRIO_EN
  assign win_s = 1'b0;
`else
  logic ptr_r, ptr_s;

  assign win_s = ptr_r;

  // Pointer moves to the losing lane whenever both lanes compete
  always_comb begin
    ptr_s = ptr_r;
    if (state_r == ST_IDLE && req0 && req1) begin
      ptr_s = ~ptr_r;
    end else begin
      ptr_s = ptr_r;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_s;
    end
  end
`endif

  // Next-state, grant selection and completion decode
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    pend_s      = pend_r;
    load_s      = 1'b0;
    load_lane_s = 1'b0;
    done0_s     = 1'b0;
    done1_s     = 1'b0;
    stall_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stall_s = req0 | req1;
        if (req0 && req1) begin
          load_s      = 1'b1;
          load_lane_s = win_s;
          pend_s      = 1'b1;
          state_s     = ST_BUSY;
        end else if (req0 || req1) begin
          load_s      = 1'b1;
          load_lane_s = req1;
          pend_s      = 1'b0;
          state_s     = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_s = 1'b1;
        if (mem_ready) begin
          done0_s = ~owner_r;
          done1_s = owner_r;
          // Chain straight into the queued lane so there is no idle bubble
          if (pend_r) begin
            load_s      = 1'b1;
            load_lane_s = ~owner_r;
            pend_s      = 1'b0;
            state_s     = ST_BUSY;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pend_s  = 1'b0;
      end
    endcase
    if (load_s) begin
      owner_s = load_lane_s;
    end else begin
      owner_s = owner_r;
    end
  end

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      pend_r  <= pend_s;
    end
  end

  // Memory request payload, captured only at grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else if (load_s) begin
      mem_we_r    <= load_lane_s ? we1 : we0;
      mem_addr_r  <= load_lane_s ? addr1 : addr0;
      mem_wdata_r <= load_lane_s ? wdata1 : wdata0;
    end
  end

  assign mem_req   = (state_r == ST_BUSY);
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign done0     = done0_s;
  assign done1     = done1_s;
  assign rdata0    = done0_s ? mem_rdata : {DATA_W{1'b0}};
  assign rdata1    = done1_s ? mem_rdata : {DATA_W{1'b0}};
  // Requests held during reset must not raise stall
  assign stall     = stall_s & ~rst;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: directed vector table, corner sequences, random run vs. a queue model.
module tb_lsu_mem_arbiter;

`ifdef LSU_ARB_FIXED_PRIO_EN
  localparam logic F = 1'b1;
`else
  localparam logic F = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
  logic        done0, done1, mem_req, mem_we, stall;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic rdy;
    logic [31:0] rd;
    logic e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic e_d0, e_d1;
    logic [31:0] e_rd0, e_rd1;
    logic e_stall;
  } vec_t;

  vec_t tbl[13];

  // Behavioural model: active lane, FIFO of queued lanes, tie-break lane, last payload
  int          m_active;
  int          m_q[$];
  int          m_rr;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;

  task automatic model_reset();
    m_active = -1;
    m_q.delete();
    m_rr = 0;
    m_we = 1'b0;
    m_addr = 32'h0;
    m_wdata = 32'h0;
  endtask

  task automatic model_capture(input int l);
    m_we    = (l == 1) ? we1 : we0;
    m_addr  = (l == 1) ? addr1 : addr0;
    m_wdata = (l == 1) ? wdata1 : wdata0;
  endtask

  task automatic model_edge();
    int w;
    if (m_active >= 0) begin
      if (mem_ready) begin
        if (m_q.size() > 0) begin
          m_active = m_q.pop_front();
          model_capture(m_active);
        end else begin
          m_active = -1;
        end
      end
    end else if (req0 && req1) begin
      w = F ? 0 : m_rr;
      m_active = w;
      m_q.push_back(1 - w);
      if (!F) m_rr = 1 - w;
      model_capture(w);
    end else if (req0 || req1) begin
      m_active = req1 ? 1 : 0;
      model_capture(m_active);
    end
  endtask

  initial begin
    bit          hold[2];
    logic        lwe[2];
    logic [31:0] lad[2], lwd[2];
    bit          pdone[2];
    bit          pstall;
    logic        e_d0, e_d1, e_st;

    // r0 r1 w0 w1 a0 a1 d0 d1 rdy rd | req we addr wdata d0 d1 rd0 rd1 stall
    tbl[0]  = '{0,0,0,0, 32'h0,32'h0,32'h0,32'h0, 1,32'h55,
                0,0, 32'h0,32'h0, 0,0, 32'h0,32'h0, 0};
    tbl[1]  = '{1,0,0,0, 32'h100,32'h0,32'h0,32'h0, 0,32'h0,
                0,0, 32'h0,32'h0, 0,0, 32'h0,32'h0, 1};
    tbl[2]  = '{1,0,0,0, 32'h100,32'h0,32'h0,32'h0, 0,32'h0,
                1,0, 32'h100,32'h0, 0,0, 32'h0,32'h0, 1};
    tbl[3]  = '{1,0,0,0, 32'h100,32'h0,32'h0,32'h0, 1,32'hDEADBEEF,
                1,0, 32'h100,32'h0, 1,0, 32'hDEADBEEF,32'h0, 1};
    tbl[4]  = '{0,0,0,0, 32'h0,32'h0,32'h0,32'h0, 0,32'h0,
                0,0, 32'h100,32'h0, 0,0, 32'h0,32'h0, 0};
    tbl[5]  = '{1,1,1,1, 32'h200,32'h204,32'h11,32'h22, 1,32'h0,
                0,0, 32'h100,32'h0, 0,0, 32'h0,32'h0, 1};
    tbl[6]  = '{1,1,1,1, 32'h200,32'h204,32'h11,32'h22, 1,32'hAAAA,
                1,1, 32'h200,32'h11, 1,0, 32'hAAAA,32'h0, 1};
    tbl[7]  = '{0,1,1,1, 32'h200,32'h204,32'h11,32'h22, 1,32'hBBBB,
                1,1, 32'h204,32'h22, 0,1, 32'h0,32'hBBBB, 1};
    tbl[8]  = '{0,0,1,1, 32'h200,32'h204,32'h11,32'h22, 1,32'h0,
                0,1, 32'h204,32'h22, 0,0, 32'h0,32'h0, 0};
    tbl[9]  = '{1,1,1,1, 32'h200,32'h204,32'h11,32'h22, 1,32'h0,
                0,1, 32'h204,32'h22, 0,0, 32'h0,32'h0, 1};
    tbl[10] = '{1,1,1,1, 32'h200,32'h204,32'h11,32'h22, 1,32'hCCCC,
                1,1, F ? 32'h200 : 32'h204, F ? 32'h11 : 32'h22, F,!F,
                F ? 32'hCCCC : 32'h0, F ? 32'h0 : 32'hCCCC, 1};
    tbl[11] = '{!F,F,1,1, 32'h200,32'h204,32'h11,32'h22, 1,32'hDDDD,
                1,1, F ? 32'h204 : 32'h200, F ? 32'h22 : 32'h11, !F,F,
                F ? 32'h0 : 32'hDDDD, F ? 32'hDDDD : 32'h0, 1};
    tbl[12] = '{0,0,1,1, 32'h200,32'h204,32'h11,32'h22, 0,32'h0,
                0,1, F ? 32'h204 : 32'h200, F ? 32'h22 : 32'h11, 0,0,
                32'h0,32'h0, 0};

    // Reset state, with a request present to show stall is held low
    repeat (2) @(negedge clk);
    req0 = 1'b1;
    #1;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_done", {30'h0, done1, done0}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table: spurious ready, single load, two simultaneous pairs
    for (int i = 0; i < 13; i++) begin
      if (i != 0) @(negedge clk);
      req0 = tbl[i].r0; req1 = tbl[i].r1; we0 = tbl[i].w0; we1 = tbl[i].w1;
      addr0 = tbl[i].a0; addr1 = tbl[i].a1; wdata0 = tbl[i].d0; wdata1 = tbl[i].d1;
      mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("v%0d_mem_req", i), {31'h0, mem_req}, {31'h0, tbl[i].e_req});
      chk($sformatf("v%0d_mem_we", i), {31'h0, mem_we}, {31'h0, tbl[i].e_we});
      chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d_done0", i), {31'h0, done0}, {31'h0, tbl[i].e_d0});
      chk($sformatf("v%0d_done1", i), {31'h0, done1}, {31'h0, tbl[i].e_d1});
      chk($sformatf("v%0d_rdata0", i), rdata0, tbl[i].e_rd0);
      chk($sformatf("v%0d_rdata1", i), rdata1, tbl[i].e_rd1);
      chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, tbl[i].e_stall});
    end

    // Wait states: five cycles of mem_ready low keep the request frozen
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h300; wdata1 = 32'h33;
    mem_ready = 1'b0;
    #1;
    chk("ws_req_seen_stall", {31'h0, stall}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("ws_mem_req", {31'h0, mem_req}, 32'h1);
      chk("ws_mem_addr", mem_addr, 32'h300);
      chk("ws_mem_wdata", mem_wdata, 32'h33);
      chk("ws_no_done", {30'h0, done1, done0}, 32'h0);
      chk("ws_stall", {31'h0, stall}, 32'h1);
    end
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h1234;
    #1;
    chk("ws_done1", {31'h0, done1}, 32'h1);
    chk("ws_rdata1", rdata1, 32'h1234);
    @(negedge clk);
    req1 = 1'b0; mem_ready = 1'b0;
    #1;
    chk("ws_stall_release", {31'h0, stall}, 32'h0);

    // Reset while waiting on memory abandons the access; held request is re-issued
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h400; wdata0 = 32'h44;
    @(negedge clk);
    #1;
    chk("rb_mem_req", {31'h0, mem_req}, 32'h1);
    @(negedge clk);
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rb_mem_req_drop", {31'h0, mem_req}, 32'h0);
    chk("rb_stall_drop", {31'h0, stall}, 32'h0);
    chk("rb_no_done", {30'h0, done1, done0}, 32'h0);
    chk("rb_mem_addr_clr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rb_idle_stall", {31'h0, stall}, 32'h1);
    chk("rb_idle_mem_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    #1;
    chk("rb_reissue_req", {31'h0, mem_req}, 32'h1);
    chk("rb_reissue_addr", mem_addr, 32'h400);
    chk("rb_reissue_we", {31'h0, mem_we}, 32'h1);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h9;
    #1;
    chk("rb_done0", {31'h0, done0}, 32'h1);
    @(negedge clk);
    req0 = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rb_stall_release", {31'h0, stall}, 32'h0);

    // Randomised run against the model
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    hold[0] = 1'b0; hold[1] = 1'b0;
    pdone[0] = 1'b0; pdone[1] = 1'b0;
    pstall = 1'b0;
    lwe[0] = 1'b0; lwe[1] = 1'b0;
    lad[0] = 32'h0; lad[1] = 32'h0; lwd[0] = 32'h0; lwd[1] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        if (hold[l] && pdone[l]) begin
          if ($urandom_range(3) != 0) hold[l] = 1'b0;
        end else if (!hold[l] && !pstall && $urandom_range(1) == 1) begin
          hold[l] = 1'b1;
          lwe[l]  = 1'($urandom_range(1));
          lad[l]  = $urandom;
          lwd[l]  = $urandom;
        end
      end
      req0 = hold[0]; we0 = lwe[0]; addr0 = lad[0]; wdata0 = lwd[0];
      req1 = hold[1]; we1 = lwe[1]; addr1 = lad[1]; wdata1 = lwd[1];
      mem_ready = ($urandom_range(2) == 0);
      mem_rdata = $urandom;
      #1;
      e_d0 = (m_active == 0) && mem_ready;
      e_d1 = (m_active == 1) && mem_ready;
      e_st = (m_active >= 0) || req0 || req1;
      chk("rnd_mem_req", {31'h0, mem_req}, {31'h0, (m_active >= 0)});
      chk("rnd_mem_we", {31'h0, mem_we}, {31'h0, m_we});
      chk("rnd_mem_addr", mem_addr, m_addr);
      chk("rnd_mem_wdata", mem_wdata, m_wdata);
      chk("rnd_done0", {31'h0, done0}, {31'h0, e_d0});
      chk("rnd_done1", {31'h0, done1}, {31'h0, e_d1});
      chk("rnd_rdata0", rdata0, e_d0 ? mem_rdata : 32'h0);
      chk("rnd_rdata1", rdata1, e_d1 ? mem_rdata : 32'h0);
      chk("rnd_stall", {31'h0, stall}, {31'h0, e_st});
      model_edge();
      pdone[0] = e_d0; pdone[1] = e_d1;
      pstall = e_st;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_arbiter.md
LSU_MEM_ARBITER -- requirements
Module: lsu_mem_arbiter

Interface
REQ-001 Parameter DATA_W, 32, width of data buses.
REQ-002 Parameter ADDR_W, 32, width of address buses.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req0 / req1  input  1  lane 0 / lane 1 memory request, held until granted.
REQ-006 we0 / we1  input  1  lane request is a store (1) or load (0).
REQ-007 addr0 / addr1  input  ADDR_W  lane address.
REQ-008 wdata0 / wdata1  input  DATA_W  lane store data.
REQ-009 done0 / done1  output  1  one-cycle pulse: lane transaction completed.
REQ-010 rdata0 / rdata1  output  DATA_W  load data, valid only while matching done pulses.
REQ-011 mem_req  output  1  memory request, held until mem_ready.
REQ-012 mem_we, mem_addr, mem_wdata  output  1/ADDR_W/DATA_W  registered copy of the granted lane's request.
REQ-013 mem_ready  input  1  memory accepts and completes the current access this cycle.
REQ-014 mem_rdata  input  DATA_W  load data, valid with mem_ready.
REQ-015 stall  output  1  to hazard detection unit; freezes both lane pipelines.

Function
REQ-016 FSM states IDLE and BUSY; state, the priority pointer and the second-lane-pending flag are the only control state.
REQ-017 IDLE, no req: stay IDLE, mem_req=0, stall=0.
REQ-018 IDLE, exactly one req: register that lane's we/addr/wdata into mem_* next edge, go BUSY.
REQ-019 IDLE, both req: grant lane named by priority pointer, set second-lane-pending flag, go BUSY.
REQ-020 BUSY: mem_req=1 and mem_* stable every cycle until mem_ready sampled high.
REQ-021 BUSY with mem_ready: pulse done of granted lane the same cycle; rdata of that lane = mem_rdata combinationally; other lane rdata = 0.
REQ-022 On completion with pending flag set: load other lane's request next edge, clear flag, remain BUSY (no IDLE bubble).
REQ-023 On completion with flag clear: return to IDLE.
REQ-024 Priority pointer toggles to the non-granted lane on every grant issued when both lanes requested; unchanged after single-lane grants.
REQ-025 stall=1 from the cycle a request is seen until the cycle of the last pending lane's done pulse, inclusive; stall deasserts the cycle after.
REQ-026 Lanes hold req/we/addr/wdata constant while stall=1; arbiter samples lane buses only at grant.
REQ-027 mem_ready in IDLE is ignored; no done pulse.
REQ-028 Minimum latency: req seen at edge N, mem_req high after edge N, done no earlier than cycle N+1.
REQ-029 Lane req deasserted after its done is not re-granted; req still high after done is a new request.

Reset
REQ-030 rst forces IDLE, pointer=lane 0, pending flag=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, done0/1=0, stall=0, immediately and independent of clk.
REQ-031 Reset mid-BUSY abandons the access with no done pulse; after release, requests are re-arbitrated from IDLE.

Configuration
REQ-032 Macro LSU_ARB_FIXED_PRIO_EN: when defined, lane 0 always wins simultaneous requests and the pointer is removed; when undefined, round-robin per REQ-024.

Verification
REQ-033 Single load: req0=1, we0=0, addr0=0x100, mem_ready 2 cycles later with mem_rdata=0xDEADBEEF -> mem_addr=0x100, done0 pulse, rdata0=0xDEADBEEF, stall high throughout, low next cycle.
REQ-034 Simultaneous: req0,req1 store 0x11@0x200 and 0x22@0x204 from reset, mem_ready always 1 -> lane 0 served first, lane 1 in next cycle with no IDLE gap, stall released after done1.
REQ-035 Round-robin: repeat simultaneous pair twice -> second pair serves lane 1 first (fixed-prio build: lane 0 first both times).
REQ-036 Wait states: mem_ready low 5 cycles -> mem_req/mem_addr/mem_wdata constant all 5 cycles, no done pulse.
REQ-037 Reset mid-BUSY: assert rst while waiting on mem_ready -> mem_req=0, stall=0 same cycle, no done; after release req still high re-issued.
REQ-038 Spurious mem_ready=1 in IDLE -> no done pulse, state stays IDLE.
